// File: rtl/opll_bus_writer.sv
// OPLL host-side write sequencer: request FIFO replayed as address/data bus cycles.
// Optional register shadow with redundant-write suppression: define OPLL_WR_SHADOW_EN.
module opll_bus_writer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYC    = 2,
    parameter int ADDR_WAIT_CYC = 12,
    parameter int DATA_WAIT_CYC = 84
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [5:0]                    s_addr,
    input  logic [7:0]                    s_data,
    output logic [7:0]                    opll_d,
    output logic                          opll_a0,
    output logic                          opll_cs_n,
    output logic                          opll_we_n,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic [5:0]                    shadow_addr,
    output logic [7:0]                    shadow_data
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MW   = (ADDR_WAIT_CYC > DATA_WAIT_CYC) ? ADDR_WAIT_CYC : DATA_WAIT_CYC;
    localparam int MAXC = (MW > STROBE_CYC) ? MW : STROBE_CYC;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    typedef enum logic [3:0] {
        S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD, S_A_WAIT,
        S_D_SETUP, S_D_STROBE, S_D_HOLD, S_D_WAIT
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [5:0]      lat_addr, addr_nx;
    logic [7:0]      lat_data, data_nx;
    logic            cs_nx, we_nx, a0_nx;
    logic [7:0]      d_nx;

    logic [13:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, push, pop, drop;
    logic [5:0]      head_addr;
    logic [7:0]      head_data;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign s_ready    = !full;
    assign push       = s_valid && !full;
    assign pop        = (state == S_IDLE) && (count != '0);
    assign head_addr  = mem[rd_ptr][13:8];
    assign head_data  = mem[rd_ptr][7:0];
    assign fifo_level = count;
    assign busy       = (state != S_IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_addr, s_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

`ifdef OPLL_WR_SHADOW_EN
    logic [7:0]  shadow [64];
    logic [63:0] shadow_vld;
    logic        key_reg;

    always_ff @(posedge clk) begin
        if (pop) shadow[head_addr] <= head_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   shadow_vld <= '0;
        else if (pop) shadow_vld[head_addr] <= 1'b1;
    end

    // key-on/block/F-num writes retrigger notes, so they are never suppressed
    assign key_reg     = (head_addr >= 6'h20) && (head_addr <= 6'h28);
    assign drop        = shadow_vld[head_addr] && (shadow[head_addr] == head_data) && !key_reg;
    assign shadow_data = shadow_vld[shadow_addr] ? shadow[shadow_addr] : 8'h00;
`else
    logic shadow_unused;
    assign shadow_unused = ^shadow_addr;
    assign drop          = 1'b0;
    assign shadow_data   = 8'h00;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = lat_addr;
        data_nx  = lat_data;
        unique case (state)
            S_IDLE: if (pop) begin
                addr_nx = head_addr;
                data_nx = head_data;
                if (!drop) state_nx = S_A_SETUP;
            end
            S_A_SETUP: begin
                state_nx = S_A_STROBE;
                cnt_nx   = CW'(STROBE_CYC - 1);
            end
            S_A_STROBE: begin
                if (cnt == '0) state_nx = S_A_HOLD;
                else           cnt_nx   = cnt - CW'(1);
            end
            S_A_HOLD: begin
                if (ADDR_WAIT_CYC == 0) state_nx = S_D_SETUP;
                else begin
                    state_nx = S_A_WAIT;
                    cnt_nx   = CW'(ADDR_WAIT_CYC - 1);
                end
            end
            S_A_WAIT: begin
                if (cnt == '0) state_nx = S_D_SETUP;
                else           cnt_nx   = cnt - CW'(1);
            end
            S_D_SETUP: begin
                state_nx = S_D_STROBE;
                cnt_nx   = CW'(STROBE_CYC - 1);
            end
            S_D_STROBE: begin
                if (cnt == '0) state_nx = S_D_HOLD;
                else           cnt_nx   = cnt - CW'(1);
            end
            S_D_HOLD: begin
                if (DATA_WAIT_CYC == 0) state_nx = S_IDLE;
                else begin
                    state_nx = S_D_WAIT;
                    cnt_nx   = CW'(DATA_WAIT_CYC - 1);
                end
            end
            S_D_WAIT: begin
                if (cnt == '0) state_nx = S_IDLE;
                else           cnt_nx   = cnt - CW'(1);
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // bus pins are registered from the next state so they change cleanly on the edge
    always_comb begin
        cs_nx = 1'b1;
        we_nx = 1'b1;
        a0_nx = opll_a0;
        d_nx  = 8'h00;
        unique case (state_nx)
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                cs_nx = 1'b0;
                a0_nx = 1'b0;
                d_nx  = {2'b00, addr_nx};
                we_nx = (state_nx != S_A_STROBE);
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                cs_nx = 1'b0;
                a0_nx = 1'b1;
                d_nx  = data_nx;
                we_nx = (state_nx != S_D_STROBE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            opll_cs_n <= 1'b1;
            opll_we_n <= 1'b1;
            opll_a0   <= 1'b0;
            opll_d    <= 8'h00;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            lat_addr  <= addr_nx;
            lat_data  <= data_nx;
            opll_cs_n <= cs_nx;
            opll_we_n <= we_nx;
            opll_a0   <= a0_nx;
            opll_d    <= d_nx;
        end
    end

endmodule

// File: tb/tb_opll_bus_writer.sv
// Bench for opll_bus_writer: default-parameter instance plus a no-wait instance.
// Bus strobes are collected by a monitor and compared with a scoreboard queue.
module tb_opll_bus_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [5:0] s_addr = '0;
    logic [7:0] s_data = '0;
    logic [7:0] opll_d;
    logic       opll_a0, opll_cs_n, opll_we_n, busy;
    logic [2:0] fifo_level;
    logic [5:0] shadow_addr = '0;
    logic [7:0] shadow_data;

    logic       v6 = 1'b0;
    logic       r6;
    logic [5:0] a6 = '0;
    logic [7:0] dd6 = '0;
    logic [7:0] d6;
    logic       a06, cs6, we6, busy6;
    logic [2:0] lvl6;
    logic [7:0] sh6;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic       prev_we = 1'b1;

    logic       r_cs[0:127];
    logic       r_we[0:127];
    logic       r_a0[0:127];
    logic       r_busy[0:127];
    logic [7:0] r_d[0:127];
    logic [2:0] r_lvl[0:127];

    always #5 clk = ~clk;

    opll_bus_writer dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_addr(s_addr), .s_data(s_data),
        .opll_d(opll_d), .opll_a0(opll_a0),
        .opll_cs_n(opll_cs_n), .opll_we_n(opll_we_n),
        .busy(busy), .fifo_level(fifo_level),
        .shadow_addr(shadow_addr), .shadow_data(shadow_data)
    );

    opll_bus_writer #(
        .FIFO_DEPTH(4), .STROBE_CYC(1),
        .ADDR_WAIT_CYC(0), .DATA_WAIT_CYC(0)
    ) dut6 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(v6), .s_ready(r6),
        .s_addr(a6), .s_data(dd6),
        .opll_d(d6), .opll_a0(a06),
        .opll_cs_n(cs6), .opll_we_n(we6),
        .busy(busy6), .fifo_level(lvl6),
        .shadow_addr(6'h00), .shadow_data(sh6)
    );

    always @(negedge clk) begin
        if (!opll_cs_n && !opll_we_n && prev_we)
            obs_q.push_back({opll_a0, opll_d});
        prev_we = opll_we_n;
    end

    task automatic push1(input logic [5:0] a, input logic [7:0] d, input bit issue);
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_addr  = a;
        s_data  = d;
        if (issue) begin
            exp_q.push_back({3'b000, a});
            exp_q.push_back({1'b1, d});
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({opll_cs_n, opll_we_n, opll_d, busy, s_ready, fifo_level}
            !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got cs=%b we=%b d=%h busy=%b rdy=%b lvl=%0d want 1 1 00 0 1 0",
                     opll_cs_n, opll_we_n, opll_d, busy, s_ready, fifo_level);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid;
        exp_q.delete();
        obs_q.delete();
        push1(6'h05, 8'h11, 1'b0);
        push1(6'h06, 8'h22, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({opll_cs_n, opll_we_n, opll_d, busy, s_ready, fifo_level}
            !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid: got cs=%b we=%b d=%h busy=%b rdy=%b lvl=%0d want 1 1 00 0 1 0",
                     opll_cs_n, opll_we_n, opll_d, busy, s_ready, fifo_level);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        obs_q.delete();
        repeat (150) @(negedge clk);
        checks++;
        if ({obs_q.size() == 0, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_quiet: got strobes=%0d busy=%b want 0 0", obs_q.size(), busy);
        end
    endtask

    task automatic test_single;
        exp_q.delete();
        obs_q.delete();
        push1(6'h10, 8'hAB, 1'b1);
        for (int k = 1; k < 108; k++) begin
            @(negedge clk);
            r_cs[k]   = opll_cs_n;
            r_we[k]   = opll_we_n;
            r_a0[k]   = opll_a0;
            r_d[k]    = opll_d;
            r_busy[k] = busy;
            r_lvl[k]  = fifo_level;
        end
        checks++;
        if ({r_cs[1], r_we[1], r_lvl[1], r_busy[1]} !== {2'b11, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_c1: got cs=%b we=%b lvl=%0d busy=%b want 1 1 1 1",
                     r_cs[1], r_we[1], r_lvl[1], r_busy[1]);
        end
        checks++;
        if ({r_cs[2], r_we[2], r_a0[2], r_d[2], r_lvl[2]} !== {3'b010, 8'h10, 3'd0}) begin
            errors++;
            $display("FAIL single_asetup: got cs=%b we=%b a0=%b d=%h lvl=%0d want 0 1 0 10 0",
                     r_cs[2], r_we[2], r_a0[2], r_d[2], r_lvl[2]);
        end
        for (int k = 3; k < 5; k++) begin
            checks++;
            if ({r_cs[k], r_we[k], r_a0[k], r_d[k]} !== {3'b000, 8'h10}) begin
                errors++;
                $display("FAIL single_astrobe c%0d: got cs=%b we=%b a0=%b d=%h want 0 0 0 10",
                         k, r_cs[k], r_we[k], r_a0[k], r_d[k]);
            end
        end
        checks++;
        if ({r_cs[5], r_we[5], r_a0[5], r_d[5]} !== {3'b010, 8'h10}) begin
            errors++;
            $display("FAIL single_ahold: got cs=%b we=%b a0=%b d=%h want 0 1 0 10",
                     r_cs[5], r_we[5], r_a0[5], r_d[5]);
        end
        checks++;
        if ({r_cs[6], r_cs[17], r_we[17], r_d[17]} !== {3'b111, 8'h00}) begin
            errors++;
            $display("FAIL single_await: got cs6=%b cs17=%b we=%b d=%h want 1 1 1 00",
                     r_cs[6], r_cs[17], r_we[17], r_d[17]);
        end
        checks++;
        if ({r_cs[18], r_we[18], r_a0[18], r_d[18]} !== {3'b011, 8'hAB}) begin
            errors++;
            $display("FAIL single_dsetup: got cs=%b we=%b a0=%b d=%h want 0 1 1 ab",
                     r_cs[18], r_we[18], r_a0[18], r_d[18]);
        end
        for (int k = 19; k < 21; k++) begin
            checks++;
            if ({r_cs[k], r_we[k], r_a0[k], r_d[k]} !== {3'b001, 8'hAB}) begin
                errors++;
                $display("FAIL single_dstrobe c%0d: got cs=%b we=%b a0=%b d=%h want 0 0 1 ab",
                         k, r_cs[k], r_we[k], r_a0[k], r_d[k]);
            end
        end
        checks++;
        if ({r_cs[21], r_we[21], r_d[21], r_cs[22], r_d[22]} !== {2'b01, 8'hAB, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL single_dhold: got cs21=%b we21=%b d21=%h cs22=%b d22=%h want 0 1 ab 1 00",
                     r_cs[21], r_we[21], r_d[21], r_cs[22], r_d[22]);
        end
        checks++;
        if ({r_busy[104], r_busy[106], r_cs[105]} !== 3'b101) begin
            errors++;
            $display("FAIL single_busy: got busy104=%b busy106=%b cs105=%b want 1 0 1",
                     r_busy[104], r_busy[106], r_cs[105]);
        end
        checks++;
        if (obs_q !== exp_q) begin
            errors++;
            $display("FAIL single_pairs: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_flow;
        bit ok;
        exp_q.delete();
        obs_q.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_addr  = 6'(8 + k);
            s_data  = 8'(8'hC0 + k);
            checks++;
            if (s_ready !== (k < 5)) begin
                errors++;
                $display("FAIL flow_ready c%0d: got %b want %b", k, s_ready, (k < 5));
            end
            if (k == 5) begin
                checks++;
                if (fifo_level !== 3'd4) begin
                    errors++;
                    $display("FAIL flow_level: got %0d want 4", fifo_level);
                end
            end
            if (k < 5) begin
                exp_q.push_back({3'b000, s_addr});
                exp_q.push_back({1'b1, s_data});
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        wait_idle(900, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL flow_idle: got busy=%b after budget want 0", busy);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL flow_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL flow_pair %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort;
        exp_q.delete();
        obs_q.delete();
        push1(6'h12, 8'h34, 1'b1);
        repeat (19) @(negedge clk);
        checks++;
        if ({opll_cs_n, opll_we_n, opll_a0, opll_d} !== {3'b001, 8'h34}) begin
            errors++;
            $display("FAIL abort_strobe: got cs=%b we=%b a0=%b d=%h want 0 0 1 34",
                     opll_cs_n, opll_we_n, opll_a0, opll_d);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({opll_cs_n, opll_we_n, opll_d} !== {2'b11, 8'h00}) begin
            errors++;
            $display("FAIL abort_async: got cs=%b we=%b d=%h want 1 1 00",
                     opll_cs_n, opll_we_n, opll_d);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if ((obs_q !== exp_q) || busy) begin
            errors++;
            $display("FAIL abort_quiet: got strobes=%0d busy=%b want 2 0", obs_q.size(), busy);
        end
    endtask

    task automatic test_shadow;
        bit ok;
        exp_q.delete();
        obs_q.delete();
        push1(6'h30, 8'h55, 1'b1);
`ifdef OPLL_WR_SHADOW_EN
        push1(6'h30, 8'h55, 1'b0);
`else
        push1(6'h30, 8'h55, 1'b1);
`endif
        push1(6'h25, 8'h10, 1'b1);
        push1(6'h25, 8'h10, 1'b1);
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL shadow_idle: got busy=%b after budget want 0", busy);
        end
        checks++;
        if (obs_q !== exp_q) begin
            errors++;
            $display("FAIL shadow_pairs: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        shadow_addr = 6'h30;
        #1;
        checks++;
`ifdef OPLL_WR_SHADOW_EN
        if (shadow_data !== 8'h55) begin
            errors++;
            $display("FAIL shadow_read30: got %h want 55", shadow_data);
        end
`else
        if (shadow_data !== 8'h00) begin
            errors++;
            $display("FAIL shadow_read30: got %h want 00", shadow_data);
        end
`endif
        shadow_addr = 6'h31;
        #1;
        checks++;
        if (shadow_data !== 8'h00) begin
            errors++;
            $display("FAIL shadow_read31: got %h want 00", shadow_data);
        end
    endtask

    task automatic test_nowait;
        @(posedge clk); #1;
        v6  = 1'b1;
        a6  = 6'h01;
        dd6 = 8'h5A;
        @(posedge clk); #1;
        a6  = 6'h02;
        dd6 = 8'hA5;
        @(posedge clk); #1;
        v6  = 1'b0;
        for (int k = 2; k < 17; k++) begin
            @(negedge clk);
            r_cs[k]   = cs6;
            r_we[k]   = we6;
            r_a0[k]   = a06;
            r_d[k]    = d6;
            r_busy[k] = busy6;
        end
        checks++;
        if ({r_cs[2], r_we[2], r_a0[2], r_d[2]} !== {3'b010, 8'h01}) begin
            errors++;
            $display("FAIL nowait_asetup: got cs=%b we=%b a0=%b d=%h want 0 1 0 01",
                     r_cs[2], r_we[2], r_a0[2], r_d[2]);
        end
        checks++;
        if ({r_cs[3], r_we[3], r_cs[4], r_we[4]} !== 4'b0001) begin
            errors++;
            $display("FAIL nowait_astrobe: got cs3=%b we3=%b cs4=%b we4=%b want 0 0 0 1",
                     r_cs[3], r_we[3], r_cs[4], r_we[4]);
        end
        checks++;
        if ({r_cs[5], r_we[5], r_a0[5], r_d[5]} !== {3'b011, 8'h5A}) begin
            errors++;
            $display("FAIL nowait_dsetup: got cs=%b we=%b a0=%b d=%h want 0 1 1 5a",
                     r_cs[5], r_we[5], r_a0[5], r_d[5]);
        end
        checks++;
        if ({r_we[6], r_cs[7], r_we[7], r_cs[8]} !== 4'b0011) begin
            errors++;
            $display("FAIL nowait_dend: got we6=%b cs7=%b we7=%b cs8=%b want 0 0 1 1",
                     r_we[6], r_cs[7], r_we[7], r_cs[8]);
        end
        checks++;
        if ({r_cs[9], r_a0[9], r_d[9]} !== {2'b00, 8'h02}) begin
            errors++;
            $display("FAIL nowait_next: got cs=%b a0=%b d=%h want 0 0 02",
                     r_cs[9], r_a0[9], r_d[9]);
        end
        checks++;
        if ({r_busy[14], r_busy[15]} !== 2'b10) begin
            errors++;
            $display("FAIL nowait_busy: got busy14=%b busy15=%b want 1 0", r_busy[14], r_busy[15]);
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid;
        test_single;
        test_flow;
        test_abort;
        test_shadow;
        test_nowait;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
